// File: rtl/core_pkg.sv
// Shared core types: physical-register tags, ROB indices and the CDB broadcast packet
// reused by the bypass network and the ROB.
package core_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int ROB_ENTRIES   = 32;
    localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS);
    localparam int ROB_BITS      = $clog2(ROB_ENTRIES);

    typedef logic [PREG_BITS-1:0] preg_t;
    typedef logic [ROB_BITS-1:0]  rob_idx_t;

    typedef struct packed {
        logic        valid;
        preg_t       tag;
        logic [31:0] data;
        rob_idx_t    rob_idx;
        logic        exc;
    } cdb_pkt_t;

    localparam int PKT_BITS = $bits(cdb_pkt_t);
endpackage

// File: rtl/result_fifo.sv
// Small per-unit result buffer; power-of-two depth so the pointers wrap for free.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_BITS'(DEPTH));
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read once cnt_q says it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Buffers completed results per execution unit and grants up to CDB_WIDTH buffer heads
// per cycle, round-robin from rr_ptr, onto the registered common data bus.
module cdb_arbiter
    import core_pkg::*;
#(
    parameter int NUM_FU     = 6,
    parameter int CDB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_FU-1:0]                   fu_valid,
    output logic [NUM_FU-1:0]                   fu_ready,
    input  logic [NUM_FU-1:0][PREG_BITS-1:0]    fu_prd,
    input  logic [NUM_FU-1:0][31:0]             fu_data,
    input  logic [NUM_FU-1:0][ROB_BITS-1:0]     fu_rob_idx,
    input  logic [NUM_FU-1:0]                   fu_exc,
    output logic [CDB_WIDTH-1:0]                cdb_valid,
    output logic [CDB_WIDTH-1:0][PREG_BITS-1:0] cdb_tag,
    output logic [CDB_WIDTH-1:0][31:0]          cdb_data,
    output logic [CDB_WIDTH-1:0][ROB_BITS-1:0]  cdb_rob_idx,
    output logic [CDB_WIDTH-1:0]                cdb_exc
);
    localparam int FU_BITS = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    typedef logic [FU_BITS-1:0] fu_idx_t;

    logic [NUM_FU-1:0] push, pop, empty, full;
    cdb_pkt_t          head  [NUM_FU];
    cdb_pkt_t          cdb_q [CDB_WIDTH];
    cdb_pkt_t          cdb_d [CDB_WIDTH];
    fu_idx_t           rr_ptr_q, rr_ptr_d;

    function automatic fu_idx_t next_fu(input fu_idx_t u);
        return (u == fu_idx_t'(NUM_FU - 1)) ? '0 : fu_idx_t'(u + 1'b1);
    endfunction

    for (genvar u = 0; u < NUM_FU; u++) begin : g_fu
        cdb_pkt_t din;
        assign din = '{valid: 1'b1, tag: fu_prd[u], data: fu_data[u],
                       rob_idx: fu_rob_idx[u], exc: fu_exc[u]};
        assign fu_ready[u] = ~full[u];
        assign push[u]     = fu_valid[u] & ~full[u];

        result_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PKT_BITS)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .push  (push[u]),
            .pop   (pop[u]),
            .din   (din),
            .dout  (head[u]),
            .empty (empty[u]),
            .full  (full[u])
        );
    end

    // Scan from rr_ptr; the n-th non-empty unit found drives port n.
    always_comb begin
        fu_idx_t idx;
        int      n;
        pop      = '0;
        rr_ptr_d = rr_ptr_q;
        idx      = rr_ptr_q;
        n        = 0;
        for (int k = 0; k < CDB_WIDTH; k++) cdb_d[k] = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!empty[idx] && n < CDB_WIDTH) begin
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (n == k) cdb_d[k] = head[idx];
                end
                pop[idx] = 1'b1;
                rr_ptr_d = next_fu(idx);
                n        = n + 1;
            end
            idx = next_fu(idx);
        end
        if (flush) begin
            pop      = '0;
            rr_ptr_d = '0;
            for (int k = 0; k < CDB_WIDTH; k++) cdb_d[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) cdb_q[k] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < CDB_WIDTH; k++) cdb_q[k] <= cdb_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_valid[k]   = cdb_q[k].valid;
            cdb_tag[k]     = cdb_q[k].tag;
            cdb_data[k]    = cdb_q[k].data;
            cdb_rob_idx[k] = cdb_q[k].rob_idx;
            cdb_exc[k]     = cdb_q[k].exc;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-port and a 1-port instance share stimulus and are compared
// against a queue-based reference model of the buffering and round-robin rules.
module tb_cdb_arbiter;
    import core_pkg::*;

    localparam int NF    = 6;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [NF-1:0]                fu_valid = '0;
    logic [NF-1:0][PREG_BITS-1:0] fu_prd = '0;
    logic [NF-1:0][31:0]          fu_data = '0;
    logic [NF-1:0][ROB_BITS-1:0]  fu_rob = '0;
    logic [NF-1:0]                fu_exc = '0;

    logic [NF-1:0]               ready0, ready1;
    logic [3:0]                  cv0, ce0;
    logic [3:0][PREG_BITS-1:0]   ct0;
    logic [3:0][31:0]            cd0;
    logic [3:0][ROB_BITS-1:0]    cr0;
    logic [0:0]                  cv1, ce1;
    logic [0:0][PREG_BITS-1:0]   ct1;
    logic [0:0][31:0]            cd1;
    logic [0:0][ROB_BITS-1:0]    cr1;

    cdb_arbiter #(.NUM_FU(NF), .CDB_WIDTH(4), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_ready(ready0),
        .fu_prd(fu_prd), .fu_data(fu_data), .fu_rob_idx(fu_rob), .fu_exc(fu_exc),
        .cdb_valid(cv0), .cdb_tag(ct0), .cdb_data(cd0), .cdb_rob_idx(cr0), .cdb_exc(ce0));

    cdb_arbiter #(.NUM_FU(NF), .CDB_WIDTH(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_ready(ready1),
        .fu_prd(fu_prd), .fu_data(fu_data), .fu_rob_idx(fu_rob), .fu_exc(fu_exc),
        .cdb_valid(cv1), .cdb_tag(ct1), .cdb_data(cd1), .cdb_rob_idx(cr1), .cdb_exc(ce1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PREG_BITS-1:0] tag;
        logic [31:0]          data;
        logic [ROB_BITS-1:0]  rob;
        logic                 exc;
    } res_t;

    // Reference model: one queue per (instance, unit), a round-robin start per instance.
    res_t mq [2*NF][$];
    int   mrr [2];
    bit   exp_v [2][4];
    res_t exp_p [2][4];
    bit   acc_m [2][NF];

    task automatic model_reset();
        for (int k = 0; k < 2*NF; k++) mq[k].delete();
        for (int i = 0; i < 2; i++) begin
            mrr[i] = 0;
            for (int p = 0; p < 4; p++) exp_v[i][p] = 0;
            for (int k = 0; k < NF; k++) acc_m[i][k] = 0;
        end
    endtask

    task automatic model_edge(input int inst, input int w);
        int n, last, u;
        for (int p = 0; p < 4; p++) exp_v[inst][p] = 0;
        for (int k = 0; k < NF; k++) acc_m[inst][k] = 0;
        if (flush) begin
            for (int k = 0; k < NF; k++) mq[inst*NF+k].delete();
            mrr[inst] = 0;
            return;
        end
        for (int k = 0; k < NF; k++)
            acc_m[inst][k] = fu_valid[k] && (mq[inst*NF+k].size() < DEPTH);
        n = 0;
        last = -1;
        for (int i = 0; i < NF; i++) begin
            u = (mrr[inst] + i) % NF;
            if (n < w && mq[inst*NF+u].size() > 0) begin
                exp_v[inst][n] = 1;
                exp_p[inst][n] = mq[inst*NF+u].pop_front();
                n++;
                last = u;
            end
        end
        if (last >= 0) mrr[inst] = (last + 1) % NF;
        for (int k = 0; k < NF; k++)
            if (acc_m[inst][k])
                mq[inst*NF+k].push_back('{tag: fu_prd[k], data: fu_data[k], rob: fu_rob[k], exc: fu_exc[k]});
    endtask

    // Advance one clock: both DUTs and the model see the same edge; return at posedge+1.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            model_edge(0, 4);
            model_edge(1, 1);
        end
        #1;
    endtask

    task automatic set_fu(input int u, input int tag, input logic [31:0] data, input int rob);
        fu_valid[u] = 1'b1;
        fu_prd[u]   = PREG_BITS'(tag);
        fu_data[u]  = data;
        fu_rob[u]   = ROB_BITS'(rob);
        fu_exc[u]   = 1'b0;
    endtask

    task automatic do_flush();
        fu_valid = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cv0 !== '0 || ct0 !== '0 || cd0 !== '0 || cr0 !== '0 || ce0 !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b tag=%h data=%h rob=%h exc=%b want all zero", cv0, ct0, cd0, cr0, ce0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ready0 !== '1 || ready1 !== '1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b want 111111", ready0, ready1);
        end
    endtask

    task automatic test_single();
        set_fu(0, 5, 32'hDEADBEEF, 3);
        step();
        fu_valid = '0;
        checks++;
        if (cv0 !== 4'b0000) begin
            errors++;
            $display("FAIL single_no_passthrough: got %b want 0000", cv0);
        end
        step();
        checks++;
        if (cv0 !== 4'b0001 || ct0[0] !== 6'd5 || cd0[0] !== 32'hDEADBEEF || cr0[0] !== 5'd3 || ce0[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_bcast: got v=%b tag=%0d data=%h rob=%0d want v=0001 tag=5 data=deadbeef rob=3", cv0, ct0[0], cd0[0], cr0[0]);
        end
        checks++;
        if (cv1 !== 1'b1 || ct1[0] !== 6'd5) begin
            errors++;
            $display("FAIL single_bcast_w1: got v=%b tag=%0d want v=1 tag=5", cv1, ct1[0]);
        end
        step();
        checks++;
        if (cv0 !== 4'b0000) begin
            errors++;
            $display("FAIL single_one_cycle: got %b want 0000", cv0);
        end
    endtask

    task automatic test_all_six();
        do_flush();
        for (int u = 0; u < NF; u++) set_fu(u, 10 + u, 32'h1000 + u, u);
        step();
        fu_valid = '0;
        step();
        checks++;
        if (cv0 !== 4'b1111 || ct0[0] !== 6'd10 || ct0[1] !== 6'd11 || ct0[2] !== 6'd12 || ct0[3] !== 6'd13) begin
            errors++;
            $display("FAIL all6_first: got v=%b tags=%0d,%0d,%0d,%0d want 1111 10,11,12,13", cv0, ct0[0], ct0[1], ct0[2], ct0[3]);
        end
        step();
        checks++;
        if (cv0 !== 4'b0011 || ct0[0] !== 6'd14 || ct0[1] !== 6'd15) begin
            errors++;
            $display("FAIL all6_second: got v=%b tags=%0d,%0d want 0011 14,15", cv0, ct0[0], ct0[1]);
        end
        // rr_ptr must be back at 0: FU0 then FU5 in port order.
        set_fu(0, 20, 32'h20, 1);
        set_fu(5, 25, 32'h25, 2);
        step();
        fu_valid = '0;
        step();
        checks++;
        if (cv0 !== 4'b0011 || ct0[0] !== 6'd20 || ct0[1] !== 6'd25) begin
            errors++;
            $display("FAIL all6_rr_wrap: got v=%b tags=%0d,%0d want 0011 20,25", cv0, ct0[0], ct0[1]);
        end
    endtask

    task automatic test_starvation();
        int last_grant [3];
        do_flush();
        for (int u = 0; u < 3; u++) last_grant[u] = 0;
        for (int c = 0; c < 30; c++) begin
            for (int u = 0; u < 3; u++) set_fu(u, u*8 + (c % 8), 32'(c), u);
            step();
            if (c < 4) begin
                checks++;
                if (ready1[2] !== ((c == 0 || c == 3) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL starve_ready2 c=%0d: got %b want %b", c, ready1[2], (c == 0 || c == 3));
                end
            end
            if (c == 3) begin
                checks++;
                if (cv1 !== 1'b1 || ct1[0] !== 6'd16) begin
                    errors++;
                    $display("FAIL starve_fu2_grant: got v=%b tag=%0d want v=1 tag=16", cv1, ct1[0]);
                end
            end
            if (c >= 1) begin
                checks++;
                if (cv1 !== 1'b1) begin
                    errors++;
                    $display("FAIL starve_busy c=%0d: got v=%b want 1", c, cv1);
                end else if (ct1[0][5:3] < 3) begin
                    last_grant[ct1[0][5:3]] = c;
                end
                for (int u = 0; u < 3; u++) begin
                    checks++;
                    if (c - last_grant[u] > NF) begin
                        errors++;
                        $display("FAIL starve_bound u=%0d: waited %0d want <= %0d", u, c - last_grant[u], NF);
                    end
                end
            end
        end
        fu_valid = '0;
        repeat (8) step();
    endtask

    task automatic test_order();
        int pos7, pos8, cnt7, cnt8;
        do_flush();
        pos7 = -1; pos8 = -1; cnt7 = 0; cnt8 = 0;
        set_fu(1, 7, 32'h7, 7);
        step();
        set_fu(1, 8, 32'h8, 8);
        for (int c = 0; c < 6; c++) begin
            step();
            fu_valid = '0;
            for (int p = 0; p < 4; p++) begin
                if (cv0[p] && ct0[p] == 6'd7) begin cnt7++; if (pos7 < 0) pos7 = c; end
                if (cv0[p] && ct0[p] == 6'd8) begin cnt8++; if (pos8 < 0) pos8 = c; end
            end
        end
        checks++;
        if (cnt7 != 1 || cnt8 != 1 || pos7 < 0 || pos8 <= pos7) begin
            errors++;
            $display("FAIL order_fu1: got cnt7=%0d cnt8=%0d pos7=%0d pos8=%0d want one each, 7 before 8", cnt7, cnt8, pos7, pos8);
        end
    endtask

    task automatic test_flush();
        do_flush();
        set_fu(0, 1, 32'hA0, 1);
        set_fu(1, 2, 32'hA1, 2);
        step();
        fu_valid = '0;
        set_fu(3, 3, 32'hA3, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = '0;
        checks++;
        if (cv0 !== 4'b0000 || cv1 !== 1'b0 || ready0 !== '1 || ready1 !== '1) begin
            errors++;
            $display("FAIL flush_clear: got v=%b/%b ready=%b/%b want 0/0 all ones", cv0, cv1, ready0, ready1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (cv0 !== 4'b0000 || cv1 !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet c=%0d: got v=%b/%b want 0/0", c, cv0, cv1);
            end
        end
        set_fu(5, 35, 32'h35, 5);
        set_fu(1, 31, 32'h31, 1);
        step();
        fu_valid = '0;
        step();
        checks++;
        if (cv0 !== 4'b0011 || ct0[0] !== 6'd31 || ct0[1] !== 6'd35 || cv1 !== 1'b1 || ct1[0] !== 6'd31) begin
            errors++;
            $display("FAIL flush_rr_zero: got v=%b tags=%0d,%0d w1 v=%b tag=%0d want 0011 31,35 w1 1 31", cv0, ct0[0], ct0[1], cv1, ct1[0]);
        end
        repeat (4) step();
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int u = 0; u < NF; u++) set_fu(u, 40 + u, 32'h4000 + u, u);
        step();
        fu_valid = '0;
        step();
        checks++;
        if (cv0 !== 4'b1111) begin
            errors++;
            $display("FAIL areset_pre: got v=%b want 1111", cv0);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cv0 !== '0 || ct0 !== '0 || cd0 !== '0 || cr0 !== '0 || ce0 !== '0 || cv1 !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got v=%b tag=%h data=%h want all zero", cv0, ct0, cd0);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (cv0 !== '0 || cd0 !== '0 || ready0 !== '1 || ready1 !== '1) begin
                errors++;
                $display("FAIL areset_hold c=%0d: got v=%b data=%h ready=%b want 0 0 all ones", c, cv0, cd0, ready0);
            end
        end
        rst = 1'b1;
        step();
        step();
        checks++;
        if (cv0 !== '0 || cv1 !== '0) begin
            errors++;
            $display("FAIL areset_lost: got v=%b/%b want 0/0", cv0, cv1);
        end
    endtask

    task automatic test_random();
        bit   pend [NF];
        int   accepted, seen, cyc;
        for (int u = 0; u < NF; u++) pend[u] = 0;
        accepted = 0; seen = 0; cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            for (int u = 0; u < NF; u++) begin
                if (!pend[u] && $urandom_range(0, 99) < 60) begin
                    pend[u] = 1;
                    fu_prd[u]  = ($urandom_range(0, 7) == 0) ? '0 : PREG_BITS'($urandom);
                    fu_data[u] = $urandom;
                    fu_rob[u]  = ROB_BITS'($urandom);
                    fu_exc[u]  = 1'($urandom_range(0, 1));
                end
                fu_valid[u] = pend[u];
            end
            step();
            cyc++;
            for (int u = 0; u < NF; u++)
                if (acc_m[0][u]) begin pend[u] = 0; accepted++; end
            seen += $countones(cv0);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (cv0[p] !== exp_v[0][p] || (exp_v[0][p] && (ct0[p] !== exp_p[0][p].tag ||
                    cd0[p] !== exp_p[0][p].data || cr0[p] !== exp_p[0][p].rob || ce0[p] !== exp_p[0][p].exc))) begin
                    errors++;
                    $display("FAIL rnd_w4 cyc=%0d port=%0d: got v=%b tag=%0d data=%h rob=%0d exc=%b want v=%b tag=%0d data=%h rob=%0d exc=%b",
                             cyc, p, cv0[p], ct0[p], cd0[p], cr0[p], ce0[p],
                             exp_v[0][p], exp_p[0][p].tag, exp_p[0][p].data, exp_p[0][p].rob, exp_p[0][p].exc);
                end
            end
            checks++;
            if (cv1[0] !== exp_v[1][0] || (exp_v[1][0] && (ct1[0] !== exp_p[1][0].tag ||
                cd1[0] !== exp_p[1][0].data || cr1[0] !== exp_p[1][0].rob || ce1[0] !== exp_p[1][0].exc))) begin
                errors++;
                $display("FAIL rnd_w1 cyc=%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                         cyc, cv1[0], ct1[0], cd1[0], exp_v[1][0], exp_p[1][0].tag, exp_p[1][0].data);
            end
            for (int u = 0; u < NF; u++) begin
                checks++;
                if (ready0[u] !== (mq[u].size() < DEPTH) || ready1[u] !== (mq[NF+u].size() < DEPTH)) begin
                    errors++;
                    $display("FAIL rnd_ready cyc=%0d u=%0d: got %b/%b want %b/%b", cyc, u, ready0[u], ready1[u],
                             mq[u].size() < DEPTH, mq[NF+u].size() < DEPTH);
                end
            end
        end
        checks++;
        if (accepted < 1000) begin
            errors++;
            $display("FAIL rnd_timeout: accepted %0d want 1000 within 20000 cycles", accepted);
        end
        fu_valid = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen += $countones(cv0);
        end
        checks++;
        if (seen != accepted) begin
            errors++;
            $display("FAIL rnd_scoreboard: broadcast %0d want %0d", seen, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_six();
        test_starvation();
        test_order();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
